// File: rtl/if_stage_pipe.sv
// Instruction fetch stage with IF/ID register, PC redirect and squash.
// Optional IF_STATS_EN adds saturating fetch/stall/flush counters.
module if_stage_pipe #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        ifflush,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [31:0] instr_id,
   output logic [31:0] pc_plus4_id,
   output logic [5:0]  opcode_id,
   output logic        valid_id
`ifdef IF_STATS_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] pc_next;
   if_id_t      if_id;
   if_id_t      if_id_next;

   assign pc_plus4    = pc + 32'd4;
   assign jump_target = {if_id.pc_plus4[31:28],
                         if_id.instr[25:0], 2'b00};

   // jump outranks branch_taken even on the illegal both-set encoding
   always_comb begin
      pc_next = pc_plus4;
      unique case (1'b1)
         jump:                  pc_next = jump_target;
         (!jump & branch_taken): pc_next = {branch_target[31:2], 2'b00};
         default:               pc_next = pc_plus4;
      endcase
   end

   always_comb begin
      if_id_next.pc_plus4 = pc_plus4;
      if_id_next.instr    = imem_data;
      if_id_next.valid    = 1'b1;
      if (ifflush) begin
         if_id_next.instr = 32'h0;
         if_id_next.valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= PC_RESET;
         if_id <= '0;
      end else if (!stall) begin
         pc    <= pc_next;
         if_id <= if_id_next;
      end
   end

   assign imem_addr   = pc;
   assign instr_id    = if_id.instr;
   assign pc_plus4_id = if_id.pc_plus4;
   assign opcode_id   = if_id.instr[31:26];
   assign valid_id    = if_id.valid;

`ifdef IF_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
         if (!stall && ifflush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 32'd1;
         if (!stall && !ifflush && fetch_cnt != '1)
            fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: cycle model plus literal checks.
module tb_if_stage_pipe;

   localparam logic [31:0] PCR = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        reset, stall, ifflush, jump, branch_taken;
   logic [31:0] branch_target, imem_data;
   logic [31:0] imem_addr, instr_id, pc_plus4_id;
   logic [5:0]  opcode_id;
   logic        valid_id;
`ifdef IF_STATS_EN
   logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_stage_pipe #(.PC_RESET(PCR)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .ifflush(ifflush), .jump(jump),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .imem_data(imem_data), .imem_addr(imem_addr),
      .instr_id(instr_id), .pc_plus4_id(pc_plus4_id),
      .opcode_id(opcode_id), .valid_id(valid_id)
`ifdef IF_STATS_EN
      , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   // instruction memory: a few fixed words, otherwise the address itself
   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h2008_0005;
         32'h0000_0044: return 32'h2009_0003;
         32'h0000_0048: return 32'h0109_5020;
         32'h1000_0004: return 32'h0800_0010;
         default:       return a;
      endcase
   endfunction

   assign imem_data = imem(imem_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference model: architectural fetch rules
   logic [31:0] m_pc, m_instr, m_p4;
   logic        m_valid;
   logic        m_ready = 1'b0;
   longint      m_fetch, m_stall, m_flush;

   always @(posedge clk) begin
      if (reset) begin
         m_pc    <= PCR;
         m_instr <= 32'h0;
         m_p4    <= 32'h0;
         m_valid <= 1'b0;
         m_fetch <= 0;
         m_stall <= 0;
         m_flush <= 0;
         m_ready <= 1'b1;
      end else if (stall) begin
         m_stall <= m_stall + 1;
      end else begin
         if (jump)
            m_pc <= (m_p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
         else if (branch_taken)
            m_pc <= branch_target & ~32'd3;
         else
            m_pc <= m_pc + 32'd4;
         m_p4 <= m_pc + 32'd4;
         if (ifflush) begin
            m_instr <= 32'h0;
            m_valid <= 1'b0;
            m_flush <= m_flush + 1;
         end else begin
            m_instr <= imem(m_pc);
            m_valid <= 1'b1;
            m_fetch <= m_fetch + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("instr_id", instr_id, m_instr);
         chk("pc_plus4_id", pc_plus4_id, m_p4);
         chk("opcode_id", {26'h0, opcode_id}, {26'h0, m_instr[31:26]});
         chk("valid_id", {31'h0, valid_id}, {31'h0, m_valid});
`ifdef IF_STATS_EN
         chk("fetch_cnt", fetch_cnt, 32'(m_fetch));
         chk("stall_cnt", stall_cnt, 32'(m_stall));
         chk("flush_cnt", flush_cnt, 32'(m_flush));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ctl(input logic s, input logic f, input logic j,
                      input logic b, input logic [31:0] t);
      stall = s; ifflush = f; jump = j;
      branch_taken = b; branch_target = t;
   endtask

   initial begin
      reset = 1'b1;
      ctl(0, 0, 0, 0, 32'h0);
      cyc(); cyc();
      chk("rst_pc", imem_addr, 32'h40);
      chk("rst_valid", {31'h0, valid_id}, 32'h0);
      chk("rst_instr", instr_id, 32'h0);
      reset = 1'b0;
      cyc();
      chk("f1_pc", imem_addr, 32'h44);
      chk("f1_instr", instr_id, 32'h2008_0005);
      chk("f1_p4", pc_plus4_id, 32'h44);
      cyc();
      chk("f2_instr", instr_id, 32'h2009_0003);
      ctl(1, 0, 0, 0, 32'h0);
      cyc(); cyc();
      chk("stall_pc", imem_addr, 32'h48);
      chk("stall_instr", instr_id, 32'h2009_0003);
      chk("stall_p4", pc_plus4_id, 32'h48);
      ctl(0, 0, 0, 0, 32'h0);
      cyc();
      chk("rel_pc", imem_addr, 32'h4C);
      chk("rel_instr", instr_id, 32'h0109_5020);
      ctl(0, 1, 0, 1, 32'h1000_0007);
      cyc();
      chk("br_pc", imem_addr, 32'h1000_0004);
      ctl(0, 0, 0, 0, 32'h0);
      cyc();
      chk("j_instr", instr_id, 32'h0800_0010);
      chk("j_p4", pc_plus4_id, 32'h1000_0008);
      ctl(1, 1, 1, 0, 32'h0);
      cyc();
      chk("sj_pc", imem_addr, 32'h1000_0008);
      chk("sj_valid", {31'h0, valid_id}, 32'h1);
      ctl(0, 1, 1, 0, 32'h0);
      cyc();
      chk("j_pc", imem_addr, 32'h1000_0040);
      chk("j_squash", instr_id, 32'h0);
      chk("j_valid", {31'h0, valid_id}, 32'h0);
      ctl(0, 1, 0, 1, 32'h0000_0123);
      cyc();
      chk("b123_pc", imem_addr, 32'h120);
      chk("b123_instr", instr_id, 32'h0);
      ctl(0, 0, 0, 0, 32'h0);
      cyc();
      chk("seq_pc", imem_addr, 32'h124);
      chk("seq_instr", instr_id, 32'h120);
      ctl(0, 1, 1, 1, 32'h200);
      cyc();
      chk("jb_pc", imem_addr, 32'h480);
      ctl(0, 1, 0, 1, 32'hFFFF_FFFF);
      cyc();
      chk("top_pc", imem_addr, 32'hFFFF_FFFC);
      ctl(0, 0, 0, 0, 32'h0);
      cyc();
      chk("wrap_pc", imem_addr, 32'h0);
      chk("wrap_p4", pc_plus4_id, 32'h0);
      chk("wrap_instr", instr_id, 32'hFFFF_FFFC);
`ifdef IF_STATS_EN
      chk("lit_fetch", fetch_cnt, 32'd6);
      chk("lit_stall", stall_cnt, 32'd3);
      chk("lit_flush", flush_cnt, 32'd5);
`endif
      cyc();
      ctl(1, 1, 1, 0, 32'h0);
      reset = 1'b1;
      cyc();
      chk("mrst_pc", imem_addr, 32'h40);
      chk("mrst_p4", pc_plus4_id, 32'h0);
      chk("mrst_valid", {31'h0, valid_id}, 32'h0);
      ctl(0, 0, 0, 0, 32'h0);
      reset = 1'b0;
      cyc(); cyc();
      chk("post_instr", instr_id, 32'h2009_0003);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
